// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline slice: instruction words and the
// program-loader state encoding.
package mips_pkg;

   localparam int          NBITS_DEFAULT     = 32;
   localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } load_state_e;

endpackage

// File: rtl/ensamblador_palabra.sv
// Packs an MSB-first byte stream into instruction words; word_valid marks the
// byte that completes a word, with the finished word presented on 'word'.
module ensamblador_palabra #(
   parameter int NBITS = 32,
   parameter int NBYTE = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             clear,
   input  logic             take,
   input  logic [NBYTE-1:0] data_byte,
   output logic [NBITS-1:0] word,
   output logic             word_valid
);

   localparam int BPW   = NBITS / NBYTE;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [NBITS-1:0] shreg_r;
   logic [NBITS-1:0] word_s;
   logic             word_valid_s;

   // Candidate word if this byte is taken; a clear in the same cycle cancels completion.
   always_comb begin
      word_s       = {shreg_r[NBITS-NBYTE-1:0], data_byte};
      word_valid_s = take && !clear && (cnt_r == LAST_CNT);
   end

   // Shift register and byte-slot counter; clear discards any partial word.
   always_ff @(posedge i_clk) begin
      if (i_reset || clear) begin
         cnt_r   <= {CNT_W{1'b0}};
         shreg_r <= {NBITS{1'b0}};
      end else if (take) begin
         shreg_r <= word_s;
         cnt_r   <= (cnt_r == LAST_CNT) ? {CNT_W{1'b0}} : cnt_r + 1'b1;
      end
   end

   assign word       = word_s;
   assign word_valid = word_valid_s;

endmodule

// File: rtl/memoria_instrucciones_programable.sv
// Run-time loadable instruction memory: a UART byte stream fills it up to the
// HALT word, then the IF stage fetches through a registered, checked port.
module memoria_instrucciones_programable
   import mips_pkg::*;
#(
   parameter int               NBITS     = NBITS_DEFAULT,
   parameter int               NBYTE     = 8,
   parameter int               CELDAS    = 256,
   parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT),
   localparam int              ADDR_W    = $clog2(CELDAS)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load_start,
   input  logic              i_byte_valid,
   input  logic [NBYTE-1:0]  i_byte,
   output logic              o_byte_ready,
   output logic              o_load_done,
   output logic [ADDR_W:0]   o_words_loaded,
   input  logic [NBITS-1:0]  i_PC,
   input  logic              i_stall,
   input  logic              i_flush,
   output logic [NBITS-1:0]  o_Instruction,
   output logic              o_addr_error,
   output logic              o_halt,
   output logic              o_busy
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELDAS - 1);
   localparam logic [NBITS-1:0]  NOP      = NBITS'(NOP_WORD);

   load_state_e       state_r, state_n;
   logic [NBITS-1:0]  mem_r [CELDAS];
   logic [ADDR_W:0]   words_r, words_n;
   logic              load_done_r, load_done_n;
   logic              byte_ready_r, busy_r;
   logic              clear_s, take_s, mem_we_s;
   logic [NBITS-1:0]  word_s;
   logic              word_valid_s;
   logic [ADDR_W-1:0] idx_s;
   logic [NBITS-1:0]  fetch_word_s;
   logic              fetch_err_s;
   logic [NBITS-1:0]  instr_r;
   logic              addr_err_r, halt_r;

   assign take_s = i_byte_valid && byte_ready_r;
   assign idx_s  = i_PC[ADDR_W+1:2];

   ensamblador_palabra #(
      .NBITS (NBITS),
      .NBYTE (NBYTE)
   ) u_ensamblador (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .clear      (clear_s),
      .take       (take_s),
      .data_byte  (i_byte),
      .word       (word_s),
      .word_valid (word_valid_s)
   );

   // Loader FSM: a start pulse always (re)enters LOAD with zeroed counters and wins over a completing word.
   always_comb begin
      state_n     = state_r;
      words_n     = words_r;
      load_done_n = 1'b0;
      clear_s     = 1'b0;
      mem_we_s    = 1'b0;
      case (state_r)
         IDLE, READY: begin
            if (i_load_start) begin
               state_n = LOAD;
               words_n = {(ADDR_W+1){1'b0}};
               clear_s = 1'b1;
            end else begin
               state_n = state_r;
            end
         end
         LOAD: begin
            if (i_load_start) begin
               words_n = {(ADDR_W+1){1'b0}};
               clear_s = 1'b1;
            end else if (word_valid_s) begin
               mem_we_s = 1'b1;
               words_n  = words_r + 1'b1;
               if ((word_s == HALT_WORD) || (words_r[ADDR_W-1:0] == LAST_IDX)) begin
                  state_n     = READY;
                  load_done_n = 1'b1;
               end else begin
                  state_n = LOAD;
               end
            end else begin
               state_n = LOAD;
            end
         end
         default: begin
            state_n = IDLE;
            words_n = {(ADDR_W+1){1'b0}};
         end
      endcase
   end

   // Loader state, word count and registered handshake outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r      <= IDLE;
         words_r      <= {(ADDR_W+1){1'b0}};
         load_done_r  <= 1'b0;
         byte_ready_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_n;
         words_r      <= words_n;
         load_done_r  <= load_done_n;
         byte_ready_r <= (state_n == LOAD);
         busy_r       <= (state_n == LOAD);
      end
   end

   // Program store write port; contents deliberately survive reset.
   always_ff @(posedge i_clk) begin
      if (mem_we_s && !i_reset) begin
         mem_r[words_r[ADDR_W-1:0]] <= word_s;
      end
   end

   // Fetch lookup: only a loaded program answers, and only for aligned in-range word addresses.
   always_comb begin
      fetch_word_s = NOP;
      fetch_err_s  = 1'b0;
      if (state_r != READY) begin
         fetch_word_s = NOP;
         fetch_err_s  = 1'b0;
      end else if ((i_PC[1:0] != 2'b00) ||
                   ((i_PC >> (ADDR_W + 2)) != {NBITS{1'b0}}) ||
                   ({1'b0, idx_s} >= words_r)) begin
         fetch_word_s = NOP;
         fetch_err_s  = 1'b1;
      end else begin
         fetch_word_s = mem_r[idx_s];
         fetch_err_s  = 1'b0;
      end
   end

   // Fetch output register: flush beats stall, stall holds everything.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         instr_r    <= NOP;
         addr_err_r <= 1'b0;
         halt_r     <= 1'b0;
      end else if (!i_stall) begin
         instr_r    <= fetch_word_s;
         addr_err_r <= fetch_err_s;
         halt_r     <= (fetch_word_s == HALT_WORD);
      end
   end

   assign o_byte_ready   = byte_ready_r;
   assign o_busy         = busy_r;
   assign o_load_done    = load_done_r;
   assign o_words_loaded = words_r;
   assign o_Instruction  = instr_r;
   assign o_addr_error   = addr_err_r;
   assign o_halt         = halt_r;

endmodule

// File: tb/tb_memoria_instrucciones_programable.sv
// Self-checking bench: a table of fetch vectors, hand-written load corner cases
// and randomized programs compared against a byte-stream reference model.
module tb_memoria_instrucciones_programable;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst, load_start, byte_valid, stall, flush;
   logic [7:0]  byte_in;
   logic [31:0] pc;

   logic        byte_ready, load_done, addr_err, halt, busy;
   logic [8:0]  words;
   logic [31:0] instr;
   logic        d4_byte_ready, d4_load_done, d4_addr_err, d4_halt, d4_busy;
   logic [2:0]  d4_words;
   logic [31:0] d4_instr;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_mem [256];

   typedef struct {
      logic [31:0] pc;
      logic        stall;
      logic        flush;
      logic [31:0] instr;
      logic        err;
      logic        halt;
   } fvec_t;
   fvec_t tbl [13];

   always #5 clk = ~clk;

   memoria_instrucciones_programable dut (
      .i_clk(clk), .i_reset(rst), .i_load_start(load_start), .i_byte_valid(byte_valid),
      .i_byte(byte_in), .o_byte_ready(byte_ready), .o_load_done(load_done),
      .o_words_loaded(words), .i_PC(pc), .i_stall(stall), .i_flush(flush),
      .o_Instruction(instr), .o_addr_error(addr_err), .o_halt(halt), .o_busy(busy)
   );

   memoria_instrucciones_programable #(.CELDAS(4)) dut4 (
      .i_clk(clk), .i_reset(rst), .i_load_start(load_start), .i_byte_valid(byte_valid),
      .i_byte(byte_in), .o_byte_ready(d4_byte_ready), .o_load_done(d4_load_done),
      .o_words_loaded(d4_words), .i_PC(pc), .i_stall(stall), .i_flush(flush),
      .o_Instruction(d4_instr), .o_addr_error(d4_addr_err), .o_halt(d4_halt), .o_busy(d4_busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_in    = b;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
   endtask

   task automatic fetch(input logic [31:0] a);
      pc = a;
      tick();
   endtask

   // Reference: group bytes four at a time MSB-first, stop at HALT or a full memory.
   task automatic model_load(input logic [7:0] bq[$], input int celdas,
                             output int nwords, output int done_at);
      logic [31:0] acc;
      int          nb;
      acc = 32'h0; nb = 0; nwords = 0; done_at = -1;
      for (int i = 0; i < bq.size(); i++) begin
         if (done_at < 0) begin
            acc = acc * 256 + 32'(bq[i]);
            nb++;
            if (nb == 4) begin
               exp_mem[nwords] = acc;
               nwords++;
               nb = 0;
               if (acc == HALT || nwords == celdas) done_at = i;
            end
         end
      end
   endtask

   initial begin
      logic [7:0]  prog [8];
      logic [7:0]  bq [$];
      int          nw, done_at, n, wi, off;
      logic [31:0] w, a, e_instr;
      logic        e_err, e_halt, st;

      tbl[0]  = '{32'h0000_0000, 1'b0, 1'b0, 32'h0001_1021, 1'b0, 1'b0};
      tbl[1]  = '{32'h0000_0004, 1'b0, 1'b0, HALT,          1'b0, 1'b1};
      tbl[2]  = '{32'h0000_0008, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[3]  = '{32'h0000_0002, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[4]  = '{32'h0000_0000, 1'b0, 1'b0, 32'h0001_1021, 1'b0, 1'b0};
      tbl[5]  = '{32'h0000_0004, 1'b1, 1'b0, 32'h0001_1021, 1'b0, 1'b0};
      tbl[6]  = '{32'h0000_0004, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
      tbl[7]  = '{32'h0000_0004, 1'b0, 1'b0, HALT,          1'b0, 1'b1};
      tbl[8]  = '{32'h0000_0000, 1'b1, 1'b0, HALT,          1'b0, 1'b1};
      tbl[9]  = '{32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
      tbl[10] = '{32'h0000_0400, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[11] = '{32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[12] = '{32'h0000_0003, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

      rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      pc = 32'h0; stall = 1'b0; flush = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state and fetch while nothing is loaded
      check("rst_instr", 64'(instr), 64'h0);
      check("rst_halt", 64'(halt), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_words", 64'(words), 64'h0);
      check("rst_done", 64'(load_done), 64'h0);
      check("rst_ready", 64'(byte_ready), 64'h0);
      fetch(32'h0);
      check("idle_instr", 64'(instr), 64'h0);
      check("idle_err", 64'(addr_err), 64'h0);

      // Basic load: one instruction then HALT
      prog = '{8'h00, 8'h01, 8'h10, 8'h21, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      pulse_start();
      check("load_busy", 64'(busy), 64'h1);
      check("load_ready", 64'(byte_ready), 64'h1);
      for (int i = 0; i < 8; i++) begin
         send_byte(prog[i]);
         check($sformatf("load_done_b%0d", i), 64'(load_done), 64'(i == 7));
      end
      check("load_words", 64'(words), 64'd2);
      check("load_busy_end", 64'(busy), 64'h0);
      tick();
      check("load_done_pulse", 64'(load_done), 64'h0);

      // Table-driven fetch vectors
      for (int i = 0; i < 13; i++) begin
         stall = tbl[i].stall;
         flush = tbl[i].flush;
         fetch(tbl[i].pc);
         check($sformatf("tbl%0d_instr", i), 64'(instr), 64'(tbl[i].instr));
         check($sformatf("tbl%0d_err", i), 64'(addr_err), 64'(tbl[i].err));
         check($sformatf("tbl%0d_halt", i), 64'(halt), 64'(tbl[i].halt));
      end
      stall = 1'b0; flush = 1'b0;

      // Restart mid-word discards the partial word
      pulse_start();
      send_byte(8'h11); send_byte(8'h22);
      pulse_start();
      check("rs_words0", 64'(words), 64'h0);
      send_word(32'hAABB_CCDD);
      send_word(HALT);
      check("rs_done", 64'(load_done), 64'h1);
      check("rs_words", 64'(words), 64'd2);
      fetch(32'h0);
      check("rs_instr0", 64'(instr), 64'hAABB_CCDD);
      fetch(32'h4);
      check("rs_halt", 64'(halt), 64'h1);

      // Start pulse coinciding with the final byte of a word: restart wins
      pulse_start();
      send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
      load_start = 1'b1;
      send_byte(8'hFF);
      load_start = 1'b0;
      check("coinc_done", 64'(load_done), 64'h0);
      check("coinc_busy", 64'(busy), 64'h1);
      check("coinc_words", 64'(words), 64'h0);
      send_word(HALT);
      check("coinc_words_after", 64'(words), 64'd1);
      fetch(32'h0);
      check("coinc_instr", 64'(instr), 64'(HALT));

      // Reset during a load
      pulse_start();
      send_word(32'h0102_0304);
      send_byte(8'h05); send_byte(8'h06);
      check("rl_words_mid", 64'(words), 64'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("rl_busy", 64'(busy), 64'h0);
      check("rl_words", 64'(words), 64'h0);
      check("rl_ready", 64'(byte_ready), 64'h0);
      fetch(32'h0);
      check("rl_instr", 64'(instr), 64'h0);
      check("rl_err", 64'(addr_err), 64'h0);

      // Four-cell memory fills without a HALT word
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(i + 1));
         check($sformatf("full_done_b%0d", i), 64'(d4_load_done), 64'(i == 15));
      end
      check("full_words", 64'(d4_words), 64'd4);
      check("full_ready", 64'(d4_byte_ready), 64'h0);
      check("full_busy", 64'(d4_busy), 64'h0);
      send_byte(8'h99);
      check("full_words_after", 64'(d4_words), 64'd4);
      check("full_done_after", 64'(d4_load_done), 64'h0);
      fetch(32'hC);
      check("full_instr3", 64'(d4_instr), 64'h0D0E_0F10);
      check("full_halt3", 64'(d4_halt), 64'h0);
      fetch(32'h10);
      check("full_err_oob", 64'(d4_addr_err), 64'h1);

      // Randomized programs against the reference model
      for (int it = 0; it < 4; it++) begin
         n = $urandom_range(1, 24);
         bq.delete();
         for (int k = 0; k < n; k++) begin
            w = (k == n - 1) ? HALT : $urandom;
            if (k != n - 1 && w == HALT) w = 32'h1234_5678;
            for (int j = 3; j >= 0; j--) bq.push_back(w[j*8 +: 8]);
         end
         model_load(bq, 256, nw, done_at);
         pulse_start();
         for (int i = 0; i < bq.size(); i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            send_byte(bq[i]);
            check($sformatf("rnd%0d_done_b%0d", it, i), 64'(load_done), 64'(i == done_at));
         end
         check($sformatf("rnd%0d_words", it), 64'(words), 64'(nw));
         e_instr = 32'h0; e_err = 1'b0; e_halt = 1'b0;
         for (int f = 0; f < 16; f++) begin
            wi  = $urandom_range(0, nw + 3);
            off = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            a   = 32'(wi * 4 + off);
            st  = (f != 0) && ($urandom_range(0, 4) == 0);
            stall = st;
            fetch(a);
            stall = 1'b0;
            if (!st) begin
               if (off != 0 || wi >= nw) begin
                  e_instr = 32'h0; e_err = 1'b1; e_halt = 1'b0;
               end else begin
                  e_instr = exp_mem[wi]; e_err = 1'b0; e_halt = (exp_mem[wi] == HALT);
               end
            end
            check($sformatf("rnd%0d_f%0d_instr", it, f), 64'(instr), 64'(e_instr));
            check($sformatf("rnd%0d_f%0d_err", it, f), 64'(addr_err), 64'(e_err));
            check($sformatf("rnd%0d_f%0d_halt", it, f), 64'(halt), 64'(e_halt));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memoria_instrucciones_programable.md
Name: memoria_instrucciones_programable

Overview:
Parametrised instruction memory for the MIPS pipeline, loaded at run time instead of from a fixed initial block. The UART debug unit streams the program in as a byte stream. The block assembles the bytes into words, writes them sequentially and stops on the HALT word or when memory is full. The IF stage then fetches through a registered, byte-addressed port with stall, flush, alignment/range checking and HALT detection.

Parameters:
NBITS, 32, instruction width (multiple of 8)
NBYTE, 8, load-stream byte width
CELDAS, 256, depth in words
HALT_WORD, 32'hFFFF_FFFF, program terminator / halt instruction
ADDR_W, $clog2(CELDAS), localparam word-index width

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_load_start  in  1  one-cycle pulse: start a new program load
i_byte_valid  in  1  load byte present
i_byte  in  NBYTE  load byte, MSB-first within each word
o_byte_ready  out  1  block accepts a byte this cycle
o_load_done  out  1  one-cycle pulse when load completes
o_words_loaded  out  ADDR_W+1  number of words written in the last load
i_PC  in  NBITS  byte address from the PC
i_stall  in  1  hold the fetch output
i_flush  in  1  replace the fetch output with NOP
o_Instruction  out  NBITS  fetched instruction, registered
o_addr_error  out  1  the last fetch was misaligned or beyond the loaded program
o_halt  out  1  o_Instruction == HALT_WORD
o_busy  out  1  state == LOAD

Behaviour:
- Reset (synchronous, i_reset=1 at a posedge) sets:
  - state=IDLE
  - o_Instruction=0 (NOP), o_addr_error=0, o_halt=0, o_load_done=0
  - o_words_loaded=0; byte counter=0; write index=0
  - Memory contents are not cleared.
- States:
  - IDLE: fetch returns NOP. i_load_start -> LOAD.
  - LOAD: o_byte_ready=1.
  - READY: fetch active. i_load_start -> LOAD.
- On entering LOAD: byte counter=0, write index=0, o_words_loaded=0.
- Byte acceptance (LOAD only):
  - A byte is taken when i_byte_valid && o_byte_ready.
  - Bytes shift into the word assembly register MSB-first; the 4th byte completes a word.
  - On word completion: mem[write index] <= word; write index++; o_words_loaded++.
- Load termination:
  - If the completed word == HALT_WORD: the word is still stored, state -> READY, o_load_done=1 for exactly one cycle.
  - If the last cell (index CELDAS-1) is written: same as above, even without a HALT word.
- i_load_start while in LOAD: restart. The partial word is discarded and counters are zeroed. No o_load_done pulse.
- i_load_start in the same cycle as the final byte: the restart wins; no done pulse.
- Reset during LOAD: return to IDLE. Words already written stay in memory but o_words_loaded=0.
- Fetch (latency 1 cycle), word index idx = i_PC[ADDR_W+1:2]:
  - Priority is i_flush > i_stall > normal.
  - i_flush: o_Instruction<=0, o_halt<=0, o_addr_error<=0, regardless of stall or state.
  - i_stall: all fetch outputs hold.
  - State != READY: o_Instruction<=0, o_addr_error<=0.
  - i_PC[1:0]!=0, or upper i_PC bits nonzero, or idx >= o_words_loaded: o_Instruction<=0, o_addr_error<=1.
  - Otherwise: o_Instruction<=mem[idx], o_addr_error<=0.
  - o_halt is registered alongside o_Instruction (o_Instruction == HALT_WORD).
- Memory has one write port (load) and one read port (fetch). Reads and writes never overlap because fetch is gated to READY.

Decomposition:
- Shared package mips_pkg: NOP_WORD=0, HALT_WORD default, NBITS, and the load-state encoding (IDLE=2'd0, LOAD=2'd1, READY=2'd2).
- Sub-module ensamblador_palabra: byte-to-word shift register and byte counter; outputs word_valid for one cycle.
- Top level holds the FSM, memory array and fetch register.

Test Plan:
- Reset -> o_Instruction=0, o_halt=0, o_busy=0, o_words_loaded=0; a fetch at PC=0 gives 0 with no error.
- Load bytes 00 01 10 21, then FF FF FF FF -> mem[0]=32'h00011021, mem[1]=HALT; o_load_done pulses once; o_words_loaded=2; state READY.
- After that load, PC=0 -> next cycle o_Instruction=32'h00011021. PC=4 -> HALT_WORD with o_halt=1. PC=8 -> 0 with o_addr_error=1. PC=2 -> 0 with o_addr_error=1.
- PC=0 fetched, then i_stall=1 with PC=4 -> output holds 32'h00011021. i_stall=1 and i_flush=1 together -> output 0 next cycle.
- CELDAS=4, load 4 non-HALT words -> o_load_done after the 16th byte, o_words_loaded=4, further bytes not accepted (o_byte_ready=0).
- Send 2 bytes, pulse i_load_start, then send 4 bytes AA BB CC DD followed by a HALT word -> mem[0]=32'hAABBCCDD; the partial word is discarded. Repeat with i_reset mid-load -> IDLE, o_words_loaded=0.
